// File: rtl/mem_req_arbiter.sv
// Arbitrates stores, speculative loads and instruction fetch onto one byte-serial
// memory controller. Only one command is in flight at a time, and it is held stable until done.
module mem_req_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_len,
  input  logic [31:0] st_data,
  output logic        st_done,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_len,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [63:0] if_data,
  output logic        mc_ls_sig,
  output logic        mc_ls_wr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_ls_addr,
  output logic [31:0] mc_store_val,
  input  logic        mc_ls_done,
  input  logic [31:0] mc_ls_data,
  output logic        mc_if_sig,
  output logic [31:0] mc_if_addr,
  input  logic        mc_if_done,
  input  logic [63:0] mc_if_data
);

  typedef enum logic [2:0] {IDLE, BUSY_ST, BUSY_LD, BUSY_IF, GAP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ls_sig_q, ls_sig_d;
  logic              ls_wr_q, ls_wr_d;
  logic [2:0]        len_q, len_d;
  logic [31:0]       ls_addr_q, ls_addr_d;
  logic [31:0]       st_val_q, st_val_d;
  logic              if_sig_q, if_sig_d;
  logic [31:0]       if_addr_q, if_addr_d;
  logic              st_done_q, st_done_d;
  logic              ld_done_q, ld_done_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic [63:0]       if_data_q, if_data_d;

  logic starved;
  assign starved = (cnt_q == CNT_W'(STARVE_MAX));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ls_sig_d  = ls_sig_q;
    ls_wr_d   = ls_wr_q;
    len_d     = len_q;
    ls_addr_d = ls_addr_q;
    st_val_d  = st_val_q;
    if_sig_d  = if_sig_q;
    if_addr_d = if_addr_q;
    st_done_d = 1'b0;
    ld_done_d = 1'b0;
    if_done_d = 1'b0;
    ld_data_d = ld_data_q;
    if_data_d = if_data_q;
    // A stall freezes everything; done pulses are suppressed by the defaults above.
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (st_req) begin
            state_d   = BUSY_ST;
            ls_sig_d  = 1'b1;
            ls_wr_d   = 1'b1;
            len_d     = st_len;
            ls_addr_d = st_addr;
            st_val_d  = st_data;
          end else if (!clear) begin
            if (if_req && (!ld_req || starved)) begin
              state_d   = BUSY_IF;
              if_sig_d  = 1'b1;
              if_addr_d = if_addr;
              cnt_d     = '0;
            end else if (ld_req) begin
              state_d   = BUSY_LD;
              ls_sig_d  = 1'b1;
              ls_wr_d   = 1'b0;
              len_d     = ld_len;
              ls_addr_d = ld_addr;
              if (if_req && !starved) cnt_d = cnt_q + 1'b1;
            end
          end
        end
        BUSY_ST: begin
          if (mc_ls_done) begin
            state_d   = GAP;
            ls_sig_d  = 1'b0;
            st_done_d = 1'b1;
          end
        end
        BUSY_LD: begin
          // Flush beats a same-cycle completion; the load data is discarded.
          if (clear) begin
            state_d  = GAP;
            ls_sig_d = 1'b0;
          end else if (mc_ls_done) begin
            state_d   = GAP;
            ls_sig_d  = 1'b0;
            ld_done_d = 1'b1;
            ld_data_d = mc_ls_data;
          end
        end
        BUSY_IF: begin
          if (clear) begin
            state_d  = GAP;
            if_sig_d = 1'b0;
          end else if (mc_if_done) begin
            state_d   = GAP;
            if_sig_d  = 1'b0;
            if_done_d = 1'b1;
            if_data_d = mc_if_data;
          end
        end
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ls_sig_q  <= 1'b0;
      ls_wr_q   <= 1'b0;
      len_q     <= '0;
      ls_addr_q <= '0;
      st_val_q  <= '0;
      if_sig_q  <= 1'b0;
      if_addr_q <= '0;
      st_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      if_done_q <= 1'b0;
      ld_data_q <= '0;
      if_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ls_sig_q  <= ls_sig_d;
      ls_wr_q   <= ls_wr_d;
      len_q     <= len_d;
      ls_addr_q <= ls_addr_d;
      st_val_q  <= st_val_d;
      if_sig_q  <= if_sig_d;
      if_addr_q <= if_addr_d;
      st_done_q <= st_done_d;
      ld_done_q <= ld_done_d;
      if_done_q <= if_done_d;
      ld_data_q <= ld_data_d;
      if_data_q <= if_data_d;
    end
  end

  assign st_done      = st_done_q;
  assign ld_done      = ld_done_q;
  assign if_done      = if_done_q;
  assign ld_data      = ld_data_q;
  assign if_data      = if_data_q;
  assign mc_ls_sig    = ls_sig_q;
  assign mc_ls_wr     = ls_wr_q;
  assign mc_len       = len_q;
  assign mc_ls_addr   = ls_addr_q;
  assign mc_store_val = st_val_q;
  assign mc_if_sig    = if_sig_q;
  assign mc_if_addr   = if_addr_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: grant order, starvation guard, flush, stall and reset.
module tb_mem_req_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = '0;
  logic [2:0]  st_len = '0;
  logic [31:0] st_data = '0;
  logic        st_done;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_len = '0;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [63:0] if_data;
  logic        mc_ls_sig, mc_ls_wr, mc_if_sig;
  logic [2:0]  mc_len;
  logic [31:0] mc_ls_addr, mc_store_val, mc_if_addr;
  logic        mc_ls_done = 1'b0;
  logic [31:0] mc_ls_data = '0;
  logic        mc_if_done = 1'b0;
  logic [63:0] mc_if_data = '0;

  int n_chk = 0;
  int n_err = 0;
  int st_cnt = 0, ld_cnt = 0, if_cnt = 0, both_sig = 0;

  mem_req_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mc_ls_sig(mc_ls_sig), .mc_ls_wr(mc_ls_wr), .mc_len(mc_len), .mc_ls_addr(mc_ls_addr),
    .mc_store_val(mc_store_val), .mc_ls_done(mc_ls_done), .mc_ls_data(mc_ls_data),
    .mc_if_sig(mc_if_sig), .mc_if_addr(mc_if_addr), .mc_if_done(mc_if_done), .mc_if_data(mc_if_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (st_done) st_cnt++;
    if (ld_done) ld_cnt++;
    if (if_done) if_cnt++;
    if (mc_ls_sig && mc_if_sig) both_sig++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sigs"}, {61'd0, mc_ls_sig, mc_if_sig, mc_ls_wr}, 64'd0);
    chk({tag, "_dones"}, {61'd0, st_done, ld_done, if_done}, 64'd0);
    chk({tag, "_lsaddr"}, {29'd0, mc_len, mc_ls_addr}, 64'd0);
    chk({tag, "_stval"}, {mc_store_val, mc_if_addr}, 64'd0);
    chk({tag, "_lddata"}, {32'd0, ld_data}, 64'd0);
    chk({tag, "_ifdata"}, if_data, 64'd0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Single load, done after 5 busy cycles
    ld_req = 1'b1; ld_addr = 32'h100; ld_len = 3'd4;
    tick();
    chk("ld_sig", mc_ls_sig, 1);
    chk("ld_wr", mc_ls_wr, 0);
    chk("ld_addr", mc_ls_addr, 32'h100);
    chk("ld_len", mc_len, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ld_sig_hold", {mc_ls_sig, ld_done}, 2'b10);
    end
    mc_ls_done = 1'b1; mc_ls_data = 32'hDEADBEEF;
    tick();
    chk("ld_done", ld_done, 1);
    chk("ld_data", ld_data, 32'hDEADBEEF);
    chk("ld_gap_sig", mc_ls_sig, 0);
    mc_ls_done = 1'b0; ld_req = 1'b0;
    tick();
    chk("ld_done_once", ld_done, 0);

    // Store, load and fetch all requesting together
    st_cnt = 0; ld_cnt = 0; if_cnt = 0;
    st_req = 1'b1; st_addr = 32'h40; st_len = 3'd2; st_data = 32'hA5A5;
    ld_req = 1'b1; ld_addr = 32'h80; ld_len = 3'd1;
    if_req = 1'b1; if_addr = 32'h1000;
    tick();
    chk("ord_st", {mc_ls_sig, mc_ls_wr, mc_if_sig}, 3'b110);
    chk("ord_st_len", mc_len, 2);
    mc_ls_done = 1'b1;
    tick();
    chk("ord_st_done", st_done, 1);
    mc_ls_done = 1'b0; st_req = 1'b0;
    tick();
    chk("ord_idle", {mc_ls_sig, mc_if_sig}, 2'b00);
    tick();
    chk("ord_ld", {mc_ls_sig, mc_ls_wr, mc_if_sig}, 3'b100);
    chk("ord_ld_addr", mc_ls_addr, 32'h80);
    mc_ls_done = 1'b1; mc_ls_data = 32'h11;
    tick();
    mc_ls_done = 1'b0; ld_req = 1'b0;
    tick();
    tick();
    chk("ord_if", {mc_ls_sig, mc_if_sig}, 2'b01);
    chk("ord_if_addr", mc_if_addr, 32'h1000);
    mc_if_done = 1'b1; mc_if_data = 64'h0123456789ABCDEF;
    tick();
    chk("ord_if_data", if_data, 64'h0123456789ABCDEF);
    mc_if_done = 1'b0; if_req = 1'b0;
    tick();
    tick();
    chk("ord_counts", {st_cnt[7:0], ld_cnt[7:0], if_cnt[7:0]}, 24'h010101);

    // Starvation: four loads then the fetch, then loads win again
    ld_req = 1'b1; ld_addr = 32'h200; if_req = 1'b1; if_addr = 32'h2000;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("stv_ld", {mc_ls_sig, mc_if_sig}, 2'b10);
      mc_ls_done = 1'b1;
      tick();
      mc_ls_done = 1'b0;
      tick();
    end
    tick();
    chk("stv_if", {mc_ls_sig, mc_if_sig}, 2'b01);
    mc_if_done = 1'b1; mc_if_data = 64'hFEEDFACECAFEF00D;
    tick();
    mc_if_done = 1'b0;
    tick();
    tick();
    chk("stv_ld_after", {mc_ls_sig, mc_if_sig}, 2'b10);
    mc_ls_done = 1'b1;
    tick();
    mc_ls_done = 1'b0; ld_req = 1'b0; if_req = 1'b0;
    tick();

    // Flush during fetch, coinciding with controller done
    if_cnt = 0;
    if_req = 1'b1; if_addr = 32'h3000;
    tick();
    chk("clr_if_sig", mc_if_sig, 1);
    tick();
    clear = 1'b1; mc_if_done = 1'b1; mc_if_data = 64'h5555;
    tick();
    chk("clr_if_gap", {mc_if_sig, if_done}, 2'b00);
    mc_if_done = 1'b0;
    tick();
    chk("clr_if_idle", if_done, 0);
    tick();
    chk("clr_no_grant", {mc_ls_sig, mc_if_sig}, 2'b00);
    chk("clr_if_data", if_data, 64'hFEEDFACECAFEF00D);
    chk("clr_if_cnt", if_cnt, 0);
    clear = 1'b0; if_req = 1'b0;
    tick();

    // Flush during a store does not cancel it
    st_req = 1'b1; st_addr = 32'h400; st_len = 3'd4; st_data = 32'h12345678;
    tick();
    clear = 1'b1; st_data = 32'hFFFFFFFF; st_addr = 32'h0;
    tick();
    chk("st_clr_val", mc_store_val, 32'h12345678);
    chk("st_clr_sig", {mc_ls_sig, mc_ls_wr}, 2'b11);
    tick();
    chk("st_clr_addr", mc_ls_addr, 32'h400);
    mc_ls_done = 1'b1;
    tick();
    chk("st_clr_done", st_done, 1);
    chk("st_clr_val_end", mc_store_val, 32'h12345678);
    mc_ls_done = 1'b0; clear = 1'b0; st_req = 1'b0;
    tick();

    // Stall mid-load, then async reset while busy
    ld_cnt = 0;
    ld_req = 1'b1; ld_addr = 32'h300; ld_len = 3'd2;
    tick();
    rdy = 1'b0; mc_ls_done = 1'b1; mc_ls_data = 32'hBAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", {mc_ls_sig, ld_done, mc_ls_addr}, {2'b10, 32'h300});
    end
    rdy = 1'b1; mc_ls_done = 1'b0;
    tick();
    chk("stall_busy", {mc_ls_sig, ld_done}, 2'b10);
    chk("stall_ld_cnt", ld_cnt, 0);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    ld_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_idle", {mc_ls_sig, mc_if_sig}, 2'b00);
    ld_req = 1'b1; ld_addr = 32'h44;
    tick();
    chk("post_rst_grant", {mc_ls_sig, mc_ls_addr}, {1'b1, 32'h44});
    chk("never_both_sig", both_sig, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single byte-serial memory controller between three requesters: committed stores, speculative loads (from the LS buffer) and instruction fetch (from the instruction cache).
- Grants one request at a time and latches its command into the controller's LS or fetch request port.
- Holds that command stable until the controller reports done, then returns a one-cycle done pulse and the read data to the owning requester.
- Handles pipeline flush (clear) and stall (rdy); prevents fetch starvation under back-to-back loads.

Parameters:
- STARVE_MAX, 4: consecutive load grants made while fetch is waiting; when reached, the next load/fetch contention goes to fetch.
- CNT_W, 3: width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rdy  input  1  global ready; low = stall
- clear  input  1  pipeline flush (mispredict)
- st_req  input  1  store request, held until st_done
- st_addr  input  32  store byte address
- st_len  input  3  store length in bytes: 1, 2 or 4
- st_data  input  32  store data, little-endian
- st_done  output  1  one-cycle store-complete pulse
- ld_req  input  1  load request, held until ld_done or clear
- ld_addr  input  32  load byte address
- ld_len  input  3  load length in bytes: 1, 2 or 4
- ld_done  output  1  one-cycle load-complete pulse
- ld_data  output  32  load data, valid when ld_done
- if_req  input  1  fetch request, held until if_done or clear
- if_addr  input  32  fetch address
- if_done  output  1  one-cycle fetch-complete pulse
- if_data  output  64  8 fetched bytes, valid when if_done
- mc_ls_sig  output  1  to controller: LS request
- mc_ls_wr  output  1  to controller: 0 = load, 1 = store
- mc_len  output  3  to controller: LS length
- mc_ls_addr  output  32  to controller: LS address
- mc_store_val  output  32  to controller: store data
- mc_ls_done  input  1  from controller: LS complete
- mc_ls_data  input  32  from controller: load data
- mc_if_sig  output  1  to controller: fetch request
- mc_if_addr  output  32  to controller: fetch address
- mc_if_done  input  1  from controller: fetch complete
- mc_if_data  input  64  from controller: fetch data

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; starvation counter is 0.
  - All outputs go to 0, including every mc_* output, all done pulses, ld_data and if_data.
- States:
  - IDLE: no request outstanding; grant decisions are made here.
  - BUSY_ST, BUSY_LD, BUSY_IF: one request in flight, owned by stores, loads or fetch respectively.
  - GAP: one mandatory cycle with all mc_*_sig low. The controller accepts a new request only after its done signal has dropped, and GAP gives the requester time to drop its req.
- IDLE grant when rdy=1 (next-state is registered; mc_* outputs are valid the cycle after the grant):
  - st_req wins first; a store is granted even when clear=1.
  - Otherwise, if clear=0: ld_req and if_req alone are each granted. With both present, load wins unless the starvation counter equals STARVE_MAX, in which case fetch wins.
  - Load grant while if_req=1: starvation counter +1, saturating. Fetch grant: counter := 0.
- At grant:
  - Address, length and data are latched into the mc_* registers, and the matching mc_*_sig is set to 1.
  - Store: mc_ls_wr=1. Load: mc_ls_wr=0.
  - The latched values stay stable through BUSY regardless of requester inputs.
- BUSY_x completion:
  - On the downstream done: drop the sig, capture data (ld_data or if_data), pulse the matching x_done for exactly the next cycle, go to GAP.
  - Latency from done out of the controller to the requester's done: 1 cycle.
- GAP: always goes to IDLE on the next cycle; no grant is made in GAP.
- clear while in flight:
  - BUSY_LD or BUSY_IF with clear=1: drop the sig next cycle, go to GAP, no done pulse.
  - If clear and mc_*_done arrive in the same cycle, clear wins and the data is dropped.
  - clear has no effect in BUSY_ST; the store completes normally.
- rdy=0:
  - State, latched command and counter are all held; no grant is made.
  - Done outputs are forced to 0; downstream done pulses are ignored, because the controller also suppresses done while stalled.
- mc_ls_sig and mc_if_sig are never high in the same cycle.
- Illegal inputs: req with len 0 or len > 4 is forwarded unchanged. Requester protocol violations are not checked.

Test Plan:
- Single load, ld_addr=0x100, len=4, mc_ls_done after 5 cycles with 0xDEADBEEF → mc_ls_sig high until done; ld_done one cycle later with ld_data=0xDEADBEEF; sig low in GAP.
- st_req, ld_req and if_req all raised together → order: store, load, fetch, each separated by a GAP cycle; exactly three done pulses.
- ld_req and if_req held high, loads re-requested immediately → after 4 load grants the fetch is granted; counter returns to 0.
- clear during BUSY_IF, coinciding with mc_if_done → no if_done; GAP; IDLE with if_req and clear both high → no grant.
- clear during BUSY_ST of st_data=0x12345678 → st_done still pulses; mc_store_val stable through the whole transfer.
- rdy low for 3 cycles mid-BUSY_LD, then async rst asserted in BUSY_LD → state held while stalled; after reset all outputs are 0 and state is IDLE immediately.
